// File: rtl/simon_datapath.sv
// Simon game datapath: seed capture, LFSR colour generator, 32-entry
// sequence memory, round selection/compare, LED drive and speed timer.
module simon_datapath #(
  parameter int BASE_PERIOD = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rst_seedgen,
  input  logic       start,
  input  logic       load_colour,
  input  logic       load_speed,
  input  logic [2:0] speed,
  input  logic [5:0] check_round,
  input  logic       flash_clk,
  input  logic [3:0] player_input,
  output logic       pulse,
  output logic       result,
  output logic [3:0] led
);

  localparam int CW = $clog2(BASE_PERIOD + 1);
  localparam logic [CW-1:0] BASE = CW'(BASE_PERIOD);
  localparam logic [15:0] SEED0 = 16'hACE1;

  logic [15:0]   seed_cnt;
  logic          seed_run;
  logic [15:0]   lfsr;
  logic [5:0]    wr_ptr;
  logic [2:0]    speed_reg;
  logic [CW-1:0] tmr;
  logic          running;
  logic [1:0]    mem [32];

  logic          cmd_ok;
  logic          col_we;
  logic          spd_we;
  logic          lfsr_fb;
  logic [CW-1:0] period;
  logic          tmr_wrap;
  logic [4:0]    sel_idx;
  logic          sel_ok;
  logic [3:0]    sel_oh;

  function automatic logic [3:0] onehot(input logic [1:0] c);
    logic [3:0] o;
    o = 4'b0000;
    unique case (c)
      2'd0: o = 4'b0001;
      2'd1: o = 4'b0010;
      2'd2: o = 4'b0100;
      2'd3: o = 4'b1000;
    endcase
    return o;
  endfunction

  // Lower-priority strobes only count when no reset/start is present
  assign cmd_ok = !reset && !rst_seedgen && !start;
  assign col_we = cmd_ok && load_colour && (wr_ptr < 6'd32);
  assign spd_we = cmd_ok && load_speed;

  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  assign period   = BASE >> speed_reg;
  assign tmr_wrap = running && (tmr >= period - CW'(1));

  // Index arithmetic mod 32 is exact whenever the selection is valid
  assign sel_idx = wr_ptr[4:0] - check_round[4:0];
  assign sel_ok  = (check_round != 6'd0) && (check_round <= wr_ptr);
  assign sel_oh  = onehot(mem[sel_idx]);

  always_ff @(posedge clk) begin
    if (reset) begin
      seed_cnt  <= 16'd0;
      seed_run  <= 1'b1;
      lfsr      <= SEED0;
      wr_ptr    <= 6'd0;
      speed_reg <= 3'd0;
      tmr       <= '0;
      running   <= 1'b0;
      pulse     <= 1'b0;
    end else if (rst_seedgen) begin
      seed_cnt  <= 16'd0;
      seed_run  <= 1'b1;
      wr_ptr    <= 6'd0;
      speed_reg <= 3'd0;
      tmr       <= '0;
      running   <= 1'b0;
      pulse     <= 1'b0;
    end else begin
      pulse <= tmr_wrap;
      if (running) begin
        tmr <= tmr_wrap ? '0 : tmr + CW'(1);
      end
      if (start) begin
        lfsr     <= (seed_cnt == 16'd0) ? SEED0 : seed_cnt;
        seed_run <= 1'b0;
        running  <= 1'b1;
      end else begin
        if (seed_run) begin
          seed_cnt <= seed_cnt + 16'd1;
        end
        if (col_we) begin
          lfsr   <= {lfsr[14:0], lfsr_fb};
          wr_ptr <= wr_ptr + 6'd1;
        end
        if (spd_we) begin
          speed_reg <= (speed > 3'd5) ? 3'd5 : speed;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (col_we) begin
      mem[wr_ptr[4:0]] <= lfsr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led    <= 4'b0000;
      result <= 1'b0;
    end else begin
      led    <= (sel_ok && flash_clk) ? sel_oh : 4'b0000;
      result <= sel_ok && (player_input == sel_oh);
    end
  end

endmodule

// File: tb/tb_simon_datapath.sv
// Directed bench for simon_datapath with a queue scoreboard for the
// led/result path and cycle counting for the pulse timer.
module tb_simon_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rst_seedgen = 1'b0;
  logic       start = 1'b0;
  logic       load_colour = 1'b0;
  logic       load_speed = 1'b0;
  logic [2:0] speed = 3'd0;
  logic [5:0] check_round = 6'd0;
  logic       flash_clk = 1'b0;
  logic [3:0] player_input = 4'd0;
  logic       pulse;
  logic       result;
  logic [3:0] led;

  always #5 clk = ~clk;

  simon_datapath #(.BASE_PERIOD(64)) dut (
    .clk(clk),
    .reset(reset),
    .rst_seedgen(rst_seedgen),
    .start(start),
    .load_colour(load_colour),
    .load_speed(load_speed),
    .speed(speed),
    .check_round(check_round),
    .flash_clk(flash_clk),
    .player_input(player_input),
    .pulse(pulse),
    .result(result),
    .led(led)
  );

  typedef struct {
    string      tag;
    logic [3:0] led;
    logic       res;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  logic [15:0] m_lfsr;
  logic [5:0]  m_wr;
  logic [1:0]  m_mem [32];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] oh(input logic [1:0] c);
    logic [3:0] one;
    one = 4'b0001;
    return one << c;
  endfunction

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic colour();
    load_colour = 1'b1;
    step();
    load_colour = 1'b0;
    if (m_wr < 6'd32) begin
      m_mem[m_wr[4:0]] = m_lfsr[1:0];
      m_wr = m_wr + 6'd1;
      m_lfsr = lstep(m_lfsr);
    end
  endtask

  task automatic sel(input logic [5:0] cr, input logic fl,
                     input logic [3:0] pin, input string tag);
    exp_t e;
    logic ok;
    logic [3:0] o;
    check_round = cr;
    flash_clk = fl;
    player_input = pin;
    ok = (cr != 6'd0) && (cr <= m_wr);
    o = ok ? oh(m_mem[5'(m_wr - cr)]) : 4'b0000;
    e.tag = tag;
    e.led = (ok && fl) ? o : 4'b0000;
    e.res = ok && (pin == o);
    sb.push_back(e);
    step();
    e = sb.pop_front();
    chk({e.tag, "_led"}, 32'(led), 32'(e.led));
    chk({e.tag, "_res"}, 32'(result), 32'(e.res));
  endtask

  task automatic measure(input int want, input string tag);
    int n;
    int per;
    n = 0;
    per = -1;
    while (!pulse && n < 300) begin
      step();
      n++;
    end
    if (pulse) begin
      step();
      per = 1;
      while (!pulse && per < 300) begin
        step();
        per++;
      end
      if (!pulse) per = -1;
    end
    chk(tag, 32'(per), 32'(want));
  endtask

  task automatic quiet(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (pulse !== 1'b0 || led !== 4'b0000) seen++;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    step();
    step();
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    reset = 1'b0;
    m_wr = 6'd0;
    m_lfsr = 16'hACE1;

    // No timer activity before the first start
    check_round = 6'd1;
    flash_clk = 1'b1;
    quiet(70, "no_pulse_before_start");
    flash_clk = 1'b0;
    check_round = 6'd0;

    rst_seedgen = 1'b1;
    step();
    rst_seedgen = 1'b0;
    repeat (9) step();
    start = 1'b1;
    step();
    start = 1'b0;
    m_lfsr = 16'h0009;

    colour();
    sel(6'd1, 1'b1, 4'b0010, "seed9_first");
    chk("seed9_colour1", 32'(led), 32'h2);

    colour();
    colour();
    sel(6'd3, 1'b1, oh(m_mem[0]), "r3_flash");
    chk("r3_mem0_const", 32'(led), 32'h2);
    sel(6'd3, 1'b0, oh(m_mem[0]), "r3_dark");
    sel(6'd2, 1'b1, oh(m_mem[1]), "r2_match");
    sel(6'd1, 1'b1, oh(m_mem[2]), "r1_match");
    sel(6'd2, 1'b1, oh(m_mem[1] + 2'd1), "r2_wrong");
    sel(6'd1, 1'b1, 4'b0011, "two_btn");
    sel(6'd1, 1'b1, 4'b0000, "no_btn");
    sel(6'd0, 1'b1, 4'b0001, "cr0");
    sel(6'd4, 1'b1, oh(m_mem[0]), "cr_gt_wr");

    speed = 3'd2;
    load_speed = 1'b1;
    step();
    load_speed = 1'b0;
    measure(16, "period_spd2");
    speed = 3'd7;
    load_speed = 1'b1;
    step();
    load_speed = 1'b0;
    measure(2, "period_spd7");

    // Seed of zero falls back to 0xACE1; start masks the colour strobe
    rst_seedgen = 1'b1;
    step();
    rst_seedgen = 1'b0;
    start = 1'b1;
    load_colour = 1'b1;
    step();
    start = 1'b0;
    load_colour = 1'b0;
    m_wr = 6'd0;
    m_lfsr = 16'hACE1;
    colour();
    sel(6'd2, 1'b1, 4'b0010, "start_no_write");
    sel(6'd1, 1'b1, 4'b0010, "ace1_first");
    chk("ace1_colour1", 32'(led), 32'h2);

    repeat (33) colour();
    chk("model_wr_sat", 32'(m_wr), 32'd32);
    sel(6'd1, 1'b1, oh(m_mem[31]), "mem31_kept");
    sel(6'd32, 1'b1, oh(m_mem[0]), "mem0_kept");
    sel(6'd16, 1'b0, oh(m_mem[16]), "mem16_res");
    sel(6'd33, 1'b1, oh(m_mem[31]), "cr33");
    measure(64, "period_spd0");

    speed = 3'd5;
    load_speed = 1'b1;
    step();
    load_speed = 1'b0;
    measure(2, "period_spd5");
    sel(6'd1, 1'b1, oh(m_mem[31]), "pre_reset");
    check_round = 6'd1;
    flash_clk = 1'b1;
    player_input = oh(m_mem[31]);
    reset = 1'b1;
    step();
    chk("midrst_pulse", 32'(pulse), 32'd0);
    chk("midrst_led", 32'(led), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    reset = 1'b0;
    m_wr = 6'd0;
    m_lfsr = 16'hACE1;
    quiet(80, "post_reset_idle");
    chk("post_reset_res", 32'(result), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/simon_datapath.md
SIMON_DATAPATH -- requirements
Module: simon_datapath

Interface
REQ-001 Parameter BASE_PERIOD, default 25_000_000, pulse period in clk cycles at speed 0 (minimum 64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rst_seedgen  input  1  clear seed counter, write pointer, speed and pulse timer.
REQ-005 start  input  1  one-cycle strobe; latch seed counter into LFSR.
REQ-006 load_colour  input  1  one-cycle strobe; append one colour to sequence memory.
REQ-007 load_speed  input  1  one-cycle strobe; latch speed input.
REQ-008 speed  input  3  requested speed level.
REQ-009 check_round  input  6  countdown index, 1..32; 0 = none selected.
REQ-010 flash_clk  input  1  drive LEDs with the selected colour while high.
REQ-011 player_input  input  4  player buttons, one-hot per colour.
REQ-012 pulse  output  1  one-cycle timing tick.
REQ-013 result  output  1  registered: last-cycle player_input matched the selected colour.
REQ-014 led  output  4  registered one-hot colour display.

Function
REQ-015 Command priority, highest first: reset, rst_seedgen, start, load_speed/load_colour; a lower-priority strobe in the same cycle as a higher one is ignored.
REQ-016 Seed counter: 16 bits, cleared by rst_seedgen, +1 every cycle until start, wraps 0xFFFF->0x0000.
REQ-017 On start, LFSR <= seed counter, or 0xACE1 if the counter is 0; the seed counter then stops.
REQ-018 LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left by one only on an accepted load_colour.
REQ-019 On load_colour with wr_ptr<32: mem[wr_ptr] <= LFSR[1:0]; wr_ptr +1; LFSR steps in the same cycle.
REQ-020 wr_ptr is 6 bits, saturates at 32; load_colour at 32 changes nothing.
REQ-021 Selected index = wr_ptr - check_round (6-bit); the selection is valid only when 1 <= check_round <= wr_ptr.
REQ-022 Colour encoding: 0->4'b0001, 1->4'b0010, 2->4'b0100, 3->4'b1000.
REQ-023 On load_speed, speed_reg <= min(speed, 5); speed_reg is 0 after reset or rst_seedgen.
REQ-024 Period P = BASE_PERIOD >> speed_reg.
REQ-025 Timer runs from the first start after reset/rst_seedgen: counts 0..P-1, wraps to 0, and pulse=1 for exactly the cycle after the count equals P-1.
REQ-026 A speed change takes effect at the next wrap; if the count is already >= the new P-1, the timer wraps on the next cycle.
REQ-027 Timer is held at 0 and pulse is 0 before start.
REQ-028 led <= onehot(mem[index]) when flash_clk=1 and the selection is valid, else 4'b0000; 1-cycle latency.
REQ-029 result <= 1 iff the selection is valid and player_input == onehot(mem[index]); otherwise 0.
REQ-030 Multiple buttons pressed, or no buttons pressed, gives result=0.
REQ-031 result is recomputed every cycle; latency is 1 cycle from player_input/check_round.
REQ-032 Memory: 32x2 bits, written only by load_colour; contents are not cleared and unwritten entries are never selected (REQ-021).

Reset
REQ-033 Reset values: pulse=0, result=0, led=0, wr_ptr=0, speed_reg=0, timer=0, seed counter=0, LFSR=0xACE1, timer not running.
REQ-034 Reset mid-sequence discards all progress; the next start reseeds per REQ-017.

Verification
REQ-035 Reset, then rst_seedgen, wait 9 cycles, start -> LFSR=0x0009; first load_colour writes colour 1 (LFSR[1:0]=01) to mem[0].
REQ-036 BASE_PERIOD=64: start, then load_speed with speed=2 -> pulse period 16 cycles; speed=7 -> clamps to 5, period 2.
REQ-037 Three load_colour strobes, check_round=3, flash_clk=1 -> led=onehot(mem[0]) one cycle later; with flash_clk=0, led=0.
REQ-038 Matching one-hot player_input -> result=1 next cycle; wrong colour, two buttons, or check_round=0 -> result=0.
REQ-039 34 load_colour strobes -> wr_ptr=32 and mem[31] retains the 32nd colour; start with load_colour in the same cycle -> no write occurs.
REQ-040 reset asserted mid-round with the timer running -> next cycle pulse=0, led=0, wr_ptr=0, and no pulses until the next start.
